ob_write: RTL

OB_WRITE -- requirements
Module: ob_write

---
 rtl/ob_write_pkg.sv | 48 ++++
 rtl/ob_merge.sv | 42 ++++
 rtl/ob_write.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ob_write_pkg.sv
// -----------------------------------------------------------------------------
// ob_write_pkg
// Shared definitions for the bitmap-object writeback block:
//   - state_t      : writeback sequencer states
//   - merge_sel_t  : which original phrase the merge unit patches
//   - field positions/widths inside the 64-bit object phrases
//   - phrase2_addr : phrase-2 address derived from the phrase-0 address
// -----------------------------------------------------------------------------
package ob_write_pkg;

    localparam int ADDR_W      = 21;
    localparam int PHRASE_W    = 64;

    // Phrase 0 carries the data pointer and the height.
    localparam int DATA_LSB    = 43;
    localparam int DATA_W      = 21;
    localparam int HEIGHT_LSB  = 14;
    localparam int HEIGHT_W    = 10;

    // Phrase 2 (scaled objects only) carries the remainder.
    localparam int REM_LSB     = 16;
    localparam int REM_W       = 8;

    // Phrase 2 sits two phrases above phrase 0.
    localparam int PHRASE2_OFS = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_GUARD,
        S_WAITU,
        S_WR0,
        S_WR2,
        S_FIN
    } state_t;

    typedef enum logic {
        MERGE_P0,
        MERGE_P2
    } merge_sel_t;

    // Phrase address arithmetic wraps inside the 21-bit space; the carry out
    // is intentionally dropped.
    function automatic logic [ADDR_W-1:0] phrase2_addr(input logic [ADDR_W-1:0] base);
        return base + ADDR_W'(PHRASE2_OFS);
    endfunction

endpackage

// File: rtl/ob_merge.sv
// -----------------------------------------------------------------------------
// ob_merge
// Purely combinational phrase patcher. Starts from the original object phrase
// and overwrites only the fields belonging to the selected phrase; every other
// bit passes through untouched.
//
// Ports:
//   i_phrase     in  64  original object phrase (phrase 0 or phrase 2)
//   i_newdata    in  21  updated data pointer   (phrase 0, bits 63:43)
//   i_newheight  in  10  updated height         (phrase 0, bits 23:14)
//   i_newrem     in   8  updated remainder      (phrase 2, bits 23:16)
//   i_sel        in   1  MERGE_P0 or MERGE_P2
//   o_phrase     out 64  merged phrase
// -----------------------------------------------------------------------------
module ob_merge
    import ob_write_pkg::*;
(
    input  logic [PHRASE_W-1:0] i_phrase,
    input  logic [DATA_W-1:0]   i_newdata,
    input  logic [HEIGHT_W-1:0] i_newheight,
    input  logic [REM_W-1:0]    i_newrem,
    input  merge_sel_t          i_sel,
    output logic [PHRASE_W-1:0] o_phrase
);

    // NOTE: the pass-through default is assigned first so every path through
    // this block drives o_phrase completely and no latch is inferred.
    always_comb begin
        o_phrase = i_phrase;
        case (i_sel)
            MERGE_P0: begin
                o_phrase[DATA_LSB   +: DATA_W]   = i_newdata;
                o_phrase[HEIGHT_LSB +: HEIGHT_W] = i_newheight;
            end
            MERGE_P2: begin
                o_phrase[REM_LSB +: REM_W] = i_newrem;
            end
            default: o_phrase = i_phrase;
        endcase
    end

endmodule

// File: rtl/ob_write.sv
// -----------------------------------------------------------------------------
// ob_write
// Writes a bitmap object's updated phrases back to memory. On start it kicks
// the writeback-update stage, waits for it to finish, then writes phrase 0
// (new data pointer and height) and, for scaled objects, phrase 2 (new
// remainder), and finally pulses done.
//
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  asynchronous, active-high reset
//   start      in   1  writeback request, sampled only in IDLE
//   scaled     in   1  object is scaled (phrase 2 also written), captured with start
//   objaddr    in  21  phrase address of object phrase 0, captured with start
//   phrase0    in  64  original phrase 0, captured with start
//   phrase2    in  64  original phrase 2, captured with start
//   wbkstart   out  1  one-cycle kick to the update stage
//   wbkdone    in   1  update stage idle/finished
//   newdata    in  21  updated data pointer
//   newheight  in  10  updated height
//   newrem     in   8  updated remainder
//   wr_req     out  1  memory write request
//   wr_addr    out 21  phrase write address
//   wr_data    out 64  phrase write data
//   wr_ack     in   1  write accepted this cycle
//   busy       out  1  high whenever not IDLE
//   done       out  1  one-cycle completion pulse
// -----------------------------------------------------------------------------
module ob_write
    import ob_write_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                scaled,
    input  logic [ADDR_W-1:0]   objaddr,
    input  logic [PHRASE_W-1:0] phrase0,
    input  logic [PHRASE_W-1:0] phrase2,
    output logic                wbkstart,
    input  logic                wbkdone,
    input  logic [DATA_W-1:0]   newdata,
    input  logic [HEIGHT_W-1:0] newheight,
    input  logic [REM_W-1:0]    newrem,
    output logic                wr_req,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PHRASE_W-1:0] wr_data,
    input  logic                wr_ack,
    output logic                busy,
    output logic                done
);

    state_t                r_state;

    // Object context captured with start.
    logic                  r_scaled;
    logic [ADDR_W-1:0]     r_objaddr;
    logic [PHRASE_W-1:0]   r_phrase0;
    logic [PHRASE_W-1:0]   r_phrase2;

    // Registered outputs.
    logic                  r_wbkstart;
    logic                  r_wr_req;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [PHRASE_W-1:0]   r_wr_data;
    logic                  r_busy;
    logic                  r_done;

    merge_sel_t            w_merge_sel;
    logic [PHRASE_W-1:0]   w_merge_in;
    logic [PHRASE_W-1:0]   w_merged;
    logic                  w_ack;

    // The merged phrase is only consumed on two transitions: WAITU->WR0
    // (phrase 0) and WR0->WR2 (phrase 2). Being in WR0 therefore means the
    // next phrase to load is phrase 2.
    assign w_merge_sel = (r_state == S_WR0) ? MERGE_P2 : MERGE_P0;
    assign w_merge_in  = (w_merge_sel == MERGE_P2) ? r_phrase2 : r_phrase0;

    // An acknowledge only counts while a request is actually outstanding.
    assign w_ack = wr_ack && r_wr_req;

    ob_merge u_merge (
        .i_phrase    (w_merge_in),
        .i_newdata   (newdata),
        .i_newheight (newheight),
        .i_newrem    (newrem),
        .i_sel       (w_merge_sel),
        .o_phrase    (w_merged)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_scaled   <= 1'b0;
            r_objaddr  <= '0;
            r_phrase0  <= '0;
            r_phrase2  <= '0;
            r_wbkstart <= 1'b0;
            r_wr_req   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            r_wbkstart <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_scaled   <= scaled;
                        r_objaddr  <= objaddr;
                        r_phrase0  <= phrase0;
                        r_phrase2  <= phrase2;
                        r_wbkstart <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_KICK;
                    end
                end

                S_KICK: begin
                    r_state <= S_GUARD;
                end

                // The update stage only drops wbkdone one edge after the
                // kick, so wbkdone is not trusted here.
                S_GUARD: begin
                    r_state <= S_WAITU;
                end

                S_WAITU: begin
                    if (wbkdone) begin
                        r_wr_req  <= 1'b1;
                        r_wr_addr <= r_objaddr;
                        r_wr_data <= w_merged;
                        r_state   <= S_WR0;
                    end
                end

                S_WR0: begin
                    if (w_ack) begin
                        if (r_scaled) begin
                            // Request stays high straight into the second write.
                            r_wr_addr <= phrase2_addr(r_objaddr);
                            r_wr_data <= w_merged;
                            r_state   <= S_WR2;
                        end else begin
                            r_wr_req <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_FIN;
                        end
                    end
                end

                S_WR2: begin
                    if (w_ack) begin
                        r_wr_req <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end
                end

                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_wr_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign wbkstart = r_wbkstart;
    assign wr_req   = r_wr_req;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
